// File: rtl/project_select_ctrl.sv
// project_select_ctrl
// Wishbone-controlled activation sequencer for the multi-project harness.
// Drives one-hot (or all-zero) per-project active lines and a shared
// active-low project reset. Every switch runs DRAIN -> GUARD -> RESET -> ON
// so that two projects never drive the shared pads at the same time.
//
// Optional feature: define SELECT_LOCK_EN to enable the CTRL[30] lock,
// which freezes the selection once the requesting switch reaches ON.
// The default build (macro undefined) ignores CTRL[30] and reads STATUS[11] as 0.
//
// Register map (offsets from ADDR_BASE):
//   0x0 CTRL   W: [SEL_W-1:0] index, [31] enable (taken only with wbs_sel_i == 4'hF)
//              R: {enable_req, 0..., target index}
//   0x4 STATUS R: [SEL_W-1:0] cur_sel, [8] busy, [9] on, [10] err, [11] lock
//   other offsets inside the 16-byte block: acked, read 0, writes ignored

module project_select_ctrl #(
    parameter int          NUM_PROJECTS = 16,
    parameter int          SEL_W        = 4,
    parameter logic [31:0] ADDR_BASE    = 32'h3000_0000,
    parameter int          GUARD_CYCLES = 4,
    parameter int          RST_CYCLES   = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_PROJECTS-1:0] active_o,
    output logic                    proj_rst_no,
    output logic                    busy_o
);

    // Counter holds the longer of the two timed phases without wrapping.
    localparam int CNT_MAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counters load "cycles - 1" on state entry and the phase ends when they hit 0,
    // which gives exactly GUARD_CYCLES / RST_CYCLES cycles in each phase.
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);

    // One extra bit so NUM_PROJECTS == 2**SEL_W is representable.
    localparam logic [SEL_W:0]   NUM_LIMIT  = (SEL_W + 1)'(NUM_PROJECTS);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DRAIN,
        ST_GUARD,
        ST_RESET,
        ST_ON
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [SEL_W-1:0]        target_reg;
    logic [SEL_W-1:0]        cur_sel_reg;
    logic                    enable_req_reg;
    logic                    disabling_reg;
    logic [NUM_PROJECTS-1:0] active_reg;
    logic                    proj_rst_n_reg;
    logic                    busy_reg;
    logic                    err_reg;
    logic                    ack_reg;
    logic [31:0]             dat_reg;
    logic [31:0]             rd_next;

    logic                    hit;
    logic                    bus_req;
    logic                    is_ctrl;
    logic                    is_status;
    logic                    ctrl_wr;
    logic                    idle;
    logic                    wr_en;
    logic [SEL_W-1:0]        wr_idx;
    logic                    idx_ok;
    logic                    locked;
    logic                    ctrl_start;
    logic                    ctrl_reject;
    logic [NUM_PROJECTS-1:0] target_onehot;
    logic                    unused_dat;

    genvar gi;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign hit       = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    // While ack is high the request is the one just served; ignore it so
    // back-to-back strobes ack every other cycle.
    assign bus_req   = wbs_cyc_i & wbs_stb_i & hit & ~ack_reg;
    assign is_ctrl   = (wbs_adr_i[3:0] == 4'h0);
    assign is_status = (wbs_adr_i[3:0] == 4'h4);
    assign ctrl_wr   = bus_req & wbs_we_i & is_ctrl & (wbs_sel_i == 4'hF);

    assign wr_en     = wbs_dat_i[31];
    assign wr_idx    = wbs_dat_i[SEL_W-1:0];
    assign idx_ok    = ({1'b0, wr_idx} < NUM_LIMIT);
    assign idle      = (state_reg == ST_OFF) || (state_reg == ST_ON);

    // A CTRL write starts a sequence only from a settled state, when not locked,
    // and (for an enable) only with an index that names a real project.
    assign ctrl_start  = ctrl_wr & idle & ~locked & (~wr_en | idx_ok);
    assign ctrl_reject = ctrl_wr & ~ctrl_start;

    // Data bits that never reach a register; folded here so they are visibly intentional.
    assign unused_dat = ^wbs_dat_i[30:SEL_W];

    // ------------------------------------------------------------------
    // One-hot decode of the latched target
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_PROJECTS; gi = gi + 1) begin : g_onehot
            assign target_onehot[gi] = (target_reg == SEL_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional selection lock
    // ------------------------------------------------------------------
`ifdef SELECT_LOCK_EN
    logic lock_reg;
    logic lock_pend_reg;

    assign locked = lock_reg;

    // Arm the lock with the switch that asked for it; it takes hold only when that switch reaches ON.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            lock_reg      <= 1'b0;
            lock_pend_reg <= 1'b0;
        end else begin
            if (ctrl_start) begin
                lock_pend_reg <= wr_en & wbs_dat_i[30];
            end
            if ((state_reg == ST_RESET) && (cnt_reg == '0) && lock_pend_reg) begin
                lock_reg <= 1'b1;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read data mux (registered below together with ack)
    // ------------------------------------------------------------------
    // Select read data for the current request; zero for writes and unmapped offsets.
    always_comb begin
        rd_next = '0;
        if (bus_req && !wbs_we_i) begin
            if (is_ctrl) begin
                rd_next[31]        = enable_req_reg;
                rd_next[SEL_W-1:0] = target_reg;
            end else if (is_status) begin
                rd_next[SEL_W-1:0] = cur_sel_reg;
                rd_next[8]         = busy_reg;
                rd_next[9]         = (state_reg == ST_ON);
                rd_next[10]        = err_reg;
                rd_next[11]        = locked;
            end
        end
    end

    // Registered single-cycle ack; read data is non-zero only in the ack cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            ack_reg <= bus_req;
            dat_reg <= rd_next;
        end
    end

    // ------------------------------------------------------------------
    // Activation sequencer
    // ------------------------------------------------------------------
    // Sequencer FSM with registered active/reset/busy outputs and sticky err.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg      <= ST_OFF;
            cnt_reg        <= '0;
            target_reg     <= '0;
            cur_sel_reg    <= '0;
            enable_req_reg <= 1'b0;
            disabling_reg  <= 1'b0;
            active_reg     <= '0;
            proj_rst_n_reg <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            // err is sticky until the next CTRL write that actually starts a sequence.
            if (ctrl_reject) begin
                err_reg <= 1'b1;
            end else if (ctrl_start) begin
                err_reg <= 1'b0;
            end

            case (state_reg)
                ST_OFF, ST_ON: begin
                    // Re-writing the running index is accepted: it re-resets that project.
                    if (ctrl_start) begin
                        state_reg      <= ST_DRAIN;
                        busy_reg       <= 1'b1;
                        enable_req_reg <= wr_en;
                        disabling_reg  <= ~wr_en;
                        if (wr_en) begin
                            target_reg <= wr_idx;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Keep the current project driving until the bus is idle.
                    if (!wbs_cyc_i) begin
                        state_reg      <= ST_GUARD;
                        cnt_reg        <= GUARD_LOAD;
                        active_reg     <= '0;
                        proj_rst_n_reg <= 1'b0;
                    end
                end

                ST_GUARD: begin
                    // All outputs released; nobody drives the shared pads here.
                    if (cnt_reg == '0) begin
                        if (disabling_reg) begin
                            state_reg <= ST_OFF;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg   <= ST_RESET;
                            cnt_reg     <= RST_LOAD;
                            active_reg  <= target_onehot;
                            cur_sel_reg <= target_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                ST_RESET: begin
                    // New project is enabled but held in reset.
                    if (cnt_reg == '0) begin
                        state_reg      <= ST_ON;
                        proj_rst_n_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg      <= ST_OFF;
                    active_reg     <= '0;
                    proj_rst_n_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = dat_reg;
    assign active_o    = active_reg;
    assign proj_rst_no = proj_rst_n_reg;
    assign busy_o      = busy_reg;

endmodule

// File: tb/tb_project_select_ctrl.sv
// tb_project_select_ctrl
// Self-checking bench for project_select_ctrl. The expected outputs come from a
// timeline model: each accepted switch is described by its acceptance cycle and
// the cycle the bus went idle, and the expected active/reset/busy values for any
// cycle are derived from those two numbers plus the guard and reset lengths.

module tb_project_select_ctrl;

    localparam int          NP    = 16;
    localparam int          SW    = 5;
    localparam int          G     = 4;
    localparam int          R     = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          NEVER = 1 << 30;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb   = 1'b0;
    logic        cyc   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  sel   = 4'h0;
    logic [31:0] dat_i = '0;
    logic [31:0] adr   = '0;
    wire         ack;
    wire  [31:0] dat_o;
    wire  [NP-1:0] active;
    wire         prst_n;
    wire         busy;

    project_select_ctrl #(
        .NUM_PROJECTS (NP),
        .SEL_W        (SW),
        .ADDR_BASE    (BASE),
        .GUARD_CYCLES (G),
        .RST_CYCLES   (R)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (dat_i),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .active_o    (active),
        .proj_rst_no (prst_n),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int ack_at = -1;

    typedef struct packed {
        logic [NP-1:0] act;
        logic          rst_n;
        logic          busy;
        logic          on;
        logic [SW-1:0] sel;
    } exp_t;

    // Reference model state
    exp_t          base_e   = '0;
    bit            seq_v    = 1'b0;
    bit            seq_en   = 1'b0;
    logic [SW-1:0] seq_tgt  = '0;
    int            t_acc    = 0;
    int            t_guard  = NEVER;
    bit            m_err    = 1'b0;
    bit            m_ctrl_en = 1'b0;
    logic [SW-1:0] m_ctrl_tgt = '0;

    // Expected outputs right after clock edge n.
    function automatic exp_t exp_at(int n);
        exp_t e;
        e = base_e;
        if (!seq_v || n < t_acc) return e;
        e.busy = 1'b1;
        e.on   = 1'b0;
        if (n < t_guard) return e;
        e.act   = '0;
        e.rst_n = 1'b0;
        if (n < t_guard + G) return e;
        if (!seq_en) begin
            e.busy = 1'b0;
            return e;
        end
        e.act = NP'(1) << seq_tgt;
        e.sel = seq_tgt;
        if (n < t_guard + G + R) return e;
        e.rst_n = 1'b1;
        e.busy  = 1'b0;
        e.on    = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_n, obs, expv);
        end
    endtask

    // Advance one clock and compare all outputs with the model.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc_n++;
        e = exp_at(cyc_n);
        chk("active", 32'(active), 32'(e.act));
        chk("proj_rst_n", 32'(prst_n), 32'(e.rst_n));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("ack", 32'(ack), 32'(cyc_n == ack_at));
        if (cyc_n != ack_at) chk("dat_idle", dat_o, 32'h0);
    endtask

    // One Wishbone transaction; cyc is held 'hold' extra cycles after the ack.
    task automatic bus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold, output logic [31:0] rd);
        exp_t        e;
        bit          hit_b;
        bit          started;
        logic [31:0] exp_rd;
        int          t;
        t       = cyc_n + 1;
        e       = exp_at(t - 1);
        hit_b   = (a[31:4] == BASE[31:4]);
        exp_rd  = '0;
        started = 1'b0;
        if (hit_b) begin
            ack_at = t;
            if (!wr && a[3:0] == 4'h0) begin
                exp_rd[31]     = m_ctrl_en;
                exp_rd[SW-1:0] = m_ctrl_tgt;
            end
            if (!wr && a[3:0] == 4'h4) begin
                exp_rd[SW-1:0] = e.sel;
                exp_rd[8]      = e.busy;
                exp_rd[9]      = e.on;
                exp_rd[10]     = m_err;
            end
            if (wr && a[3:0] == 4'h0 && s == 4'hF) begin
                if (e.busy) begin
                    m_err = 1'b1;
                end else if (d[31] && int'(d[SW-1:0]) >= NP) begin
                    m_err = 1'b1;
                end else begin
                    m_err     = 1'b0;
                    base_e    = e;
                    seq_v     = 1'b1;
                    seq_en    = d[31];
                    t_acc     = t;
                    t_guard   = NEVER;
                    m_ctrl_en = d[31];
                    if (d[31]) begin
                        seq_tgt    = d[SW-1:0];
                        m_ctrl_tgt = d[SW-1:0];
                    end
                    started = 1'b1;
                end
            end
        end
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = wr;
        adr   = a;
        dat_i = d;
        sel   = s;
        if (hit_b) begin
            step();
            rd = dat_o;
            if (!wr) chk("rdata", dat_o, exp_rd);
        end else begin
            repeat (4) step();
            rd = dat_o;
        end
        stb = 1'b0;
        we  = 1'b0;
        repeat (hold) step();
        cyc = 1'b0;
        if (started) t_guard = ((t_acc > cyc_n) ? t_acc : cyc_n) + 1;
        step();
        $display("bus %s adr=%h dat=%h sel=%h hold=%0d rd=%h cycle=%0d",
                 wr ? "WR" : "RD", a, d, s, hold, rd, cyc_n);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_proj_rst_n", 32'(prst_n), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        seq_v      = 1'b0;
        base_e     = '0;
        m_err      = 1'b0;
        m_ctrl_en  = 1'b0;
        m_ctrl_tgt = '0;
        ack_at     = -1;
        cyc        = 1'b0;
        stb        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset pulse done cycle=%0d", cyc_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("init_active", 32'(active), 32'h0);
        chk("init_proj_rst_n", 32'(prst_n), 32'h0);
        chk("init_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
        chk("status_reset", rd, 32'h0000_0000);
        bus(1'b0, BASE, 32'h0, 4'hF, 0, rd);
        chk("ctrl_reset", rd, 32'h0000_0000);

        // Switch on project 3
        bus(1'b1, BASE, 32'h8000_0003, 4'hF, 0, rd);
        repeat (G + R + 2) step();
        chk("active_p3", 32'(active), 32'h0000_0008);
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
        chk("status_on3", rd, 32'h0000_0203);
        bus(1'b0, BASE, 32'h0, 4'hF, 0, rd);
        chk("ctrl_p3", rd, 32'h8000_0003);

        // Switch to project 5 while holding cyc for 5 extra cycles
        bus(1'b1, BASE, 32'h8000_0005, 4'hF, 5, rd);
        repeat (G + R + 2) step();
        chk("active_p5", 32'(active), 32'h0000_0020);

        // Invalid index, then a valid write clears err
        bus(1'b1, BASE, 32'h8000_0014, 4'hF, 0, rd);
        repeat (2) step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
        chk("status_bad_idx", rd, 32'h0000_0605);
        bus(1'b1, BASE, 32'h8000_0001, 4'hF, 0, rd);
        repeat (G + R + 2) step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
        chk("status_err_clr", rd, 32'h0000_0201);

        // Write during GUARD
        bus(1'b1, BASE, 32'h8000_0002, 4'hF, 0, rd);
        bus(1'b1, BASE, 32'h8000_0007, 4'hF, 0, rd);
        repeat (G + R + 2) step();
        chk("active_p2", 32'(active), 32'h0000_0004);
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
        chk("status_busy_wr", rd, 32'h0000_0602);

        // Disable
        bus(1'b1, BASE, 32'h0000_0000, 4'hF, 0, rd);
        repeat (G + 2) step();
        chk("off_active", 32'(active), 32'h0);
        chk("off_proj_rst_n", 32'(prst_n), 32'h0);
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
        chk("status_off", rd, 32'h0000_0002);

        // Other offsets, foreign address, partial byte select
        bus(1'b0, BASE + 32'h8, 32'h0, 4'hF, 0, rd);
        chk("other_off_rd", rd, 32'h0);
        bus(1'b1, BASE + 32'hC, 32'h8000_0003, 4'hF, 0, rd);
        bus(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, rd);
        bus(1'b1, BASE, 32'h8000_0004, 4'h3, 0, rd);
        repeat (3) step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
        chk("status_ignored", rd, 32'h0000_0002);

        // Reset pulse in the middle of RESET
        bus(1'b1, BASE, 32'h8000_0009, 4'hF, 0, rd);
        for (int k = 0; k < 50 && cyc_n < t_guard + G + 2; k++) step();
        chk("in_reset_phase", 32'(active), 32'h0000_0200);
        do_reset();
        repeat (2) step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
        chk("status_after_rst", rd, 32'h0);

        // Randomized traffic against the timeline model
        for (int it = 0; it < 40; it++) begin
            logic [31:0] d;
            logic [3:0]  s;
            int          h;
            d     = 32'($urandom_range(0, 19));
            d[31] = ($urandom_range(0, 3) != 0);
            d[30] = 1'($urandom_range(0, 1));
            s     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            h     = $urandom_range(0, 3);
            bus(1'b1, BASE, d, s, h, rd);
            repeat ($urandom_range(0, 14)) step();
            if ($urandom_range(0, 1) == 1) bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0, rd);
            else if ($urandom_range(0, 2) == 0) bus(1'b1, BASE, 32'h8000_0001, 4'hF, 0, rd);
            else bus(1'b0, BASE, 32'h0, 4'hF, 0, rd);
            repeat ($urandom_range(0, 14)) step();
        end
        repeat (G + R + 4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/project_select_ctrl.md
Name: project_select_ctrl

Overview:
- Wishbone-controlled activation sequencer for the multi-project harness.
- Drives the per-project `active` lines that gate each project wrapper's tristate outputs, plus a shared active-low project reset.
- Guarantees at most one project is active at a time.
- Every switch follows a safe sequence: drain the bus, guard gap with all outputs released, then hold the new project in reset before running it.

Parameters:
- NUM_PROJECTS, 16, number of project wrappers; 1..2^SEL_W.
- SEL_W, 4, width of the project index field.
- ADDR_BASE, 32'h3000_0000, base address of the control registers; bits [3:0] must be 0.
- GUARD_CYCLES, 4, cycles with all active_o low between projects; >=1.
- RST_CYCLES, 8, cycles the new project is held in reset while active; >=1.

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_ni  input  1  asynchronous active-low reset
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte selects
- wbs_dat_i  input  32  write data
- wbs_adr_i  input  32  address
- wbs_ack_o  output  1  acknowledge
- wbs_dat_o  output  32  read data
- active_o  output  NUM_PROJECTS  one-hot or all-zero project enable
- proj_rst_no  output  1  active-low reset to all projects
- busy_o  output  1  high while a switch sequence is in progress

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_ni is asynchronous and active-low.
- Reset values:
  - state OFF; active_o=0; proj_rst_no=0; busy_o=0.
  - wbs_ack_o=0; wbs_dat_o=0; cur_sel=0; err=0.
- Address decode: hit = wbs_adr_i[31:4]==ADDR_BASE[31:4].
  - Offset 0x0: CTRL.
  - Offset 0x4: STATUS.
  - Other offsets within the block: acked; reads return 0; writes are ignored.
  - No hit: no ack, because other slaves share the bus.
- Bus handshake:
  - wbs_ack_o is registered. It asserts for exactly 1 cycle, one cycle after cyc&stb&hit while ack is low.
  - Back-to-back requests therefore ack every other cycle.
  - wbs_dat_o is valid only while ack is high and is 0 otherwise.
- CTRL write takes effect only when wbs_sel_i==4'hF; otherwise it is acked and ignored.
  - Fields: [SEL_W-1:0] index, [31] enable.
- CTRL read returns {enable_req, 0..., target index}.
- STATUS read: [SEL_W-1:0] cur_sel, [8] busy, [9] on (state==ON), [10] err.
  - err is sticky; it is cleared by the next accepted CTRL write.
- FSM states: OFF, DRAIN, GUARD, RESET, ON.
  - Accepted CTRL write in OFF or ON, with enable=1 and index<NUM_PROJECTS: latch the target, enter DRAIN.
  - Accepted CTRL write in OFF or ON, with enable=0: enter DRAIN, then GUARD, then OFF.
  - Index>=NUM_PROJECTS: no state change; err=1.
  - CTRL write while DRAIN, GUARD or RESET: acked, ignored, err=1.
  - DRAIN: active_o unchanged. Exit to GUARD on the first cycle wbs_cyc_i==0.
  - GUARD: active_o=0, proj_rst_no=0, for exactly GUARD_CYCLES cycles. Then go to RESET, or to OFF if disabling.
  - RESET: active_o=onehot(target), cur_sel=target, proj_rst_no=0, for exactly RST_CYCLES cycles. Then go to ON.
  - ON: active_o=onehot(cur_sel), proj_rst_no=1.
- Writing the currently running index while ON still runs the full sequence. This is the intended way to re-reset a project.
- busy_o=1 in DRAIN, GUARD and RESET.
- Counters are sized to hold max(GUARD_CYCLES,RST_CYCLES) with no wrap. Each counter is reloaded on state entry.
- Asynchronous reset mid-sequence returns immediately to the reset values. No project stays active.

Optional Feature:
- Macro SELECT_LOCK_EN.
- Defined:
  - CTRL bit 30 is the lock request, and STATUS bit 11 reports the lock.
  - A write that starts a valid switch with bit30=1 sets the lock once that switch reaches ON.
  - While locked, every CTRL write is acked, ignored, and sets err.
  - The lock clears only on wb_rst_ni.
- Undefined: bit 30 is ignored and STATUS bit 11 reads 0.

Test Plan:
- Reset check: reset, then read STATUS.
  - -> 0x0000_0000; active_o=0; proj_rst_no=0.
- Switch on: write CTRL=0x8000_0003 and drop cyc after the ack.
  - -> DRAIN lasts 1 cycle; active_o=0 for 4 cycles.
  - -> active_o=16'h0008 with proj_rst_no=0 for 8 cycles, then proj_rst_no=1.
  - -> STATUS reads 0x0000_0203.
- Switch while ON, holding wbs_cyc_i high 5 extra cycles: write CTRL=0x8000_0005 while project 3 runs.
  - -> active_o stays 0x0008 until cyc drops, then 4-cycle gap, then 0x0020.
- Invalid index: with NUM_PROJECTS=16 SEL_W=5, write index 20.
  - -> no state change; STATUS[10]=1.
  - -> a following valid write clears err.
- Write during busy: write CTRL again in GUARD.
  - -> acked; sequence unaffected; err=1.
- Disable and mid-sequence reset:
  - Write CTRL=0x0000_0000 while ON -> active_o=0, proj_rst_no=0, state OFF.
  - Pulse wb_rst_ni low during RESET -> outputs return to reset values within the same cycle.
